// File: rtl/stream_ctrl_pkg.sv
// Shared handshake-state encoding and index-width helper for the stream arbiter.
package stream_ctrl_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Index width for n sources; never narrower than one bit.
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Round-robin priority search: first requester strictly after last_grant, with wrap.
module rr_prio_select import stream_ctrl_pkg::*; #(
  parameter  int NUM_IN = 4,
  localparam int IDW    = idw(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDW-1:0]    last_grant,
  output logic [IDW-1:0]    grant,
  output logic              found
);

  logic [IDW-1:0] idx;

  // Walk from the farthest candidate back to the nearest so the nearest hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = IDW'((int'(last_grant) + k) % NUM_IN);
      if (req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Packet-locked round-robin stream mux with a single registered output stage.
module rr_stream_arbiter import stream_ctrl_pkg::*; #(
  parameter  int NUM_IN     = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int IDW        = idw(NUM_IN)
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_IN-1:0]            s_tvalid,
  input  logic [NUM_IN-1:0]            s_tlast,
  output logic [NUM_IN-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  output logic [IDW-1:0]               m_tid,
  input  logic                         m_tready
);

  arb_state_e                          state, state_nxt;
  logic [IDW-1:0]                      grant, last_grant, sel;
  logic                                found, accept, in_last;
  logic [NUM_IN-1:0][DATA_WIDTH-1:0]   s_data;

  assign s_data = s_tdata;

  rr_prio_select #(.NUM_IN(NUM_IN)) u_prio (
    .req        (s_tvalid),
    .last_grant (last_grant),
    .grant      (sel),
    .found      (found)
  );

  // Only the locked stream ever sees ready; it follows the output slot being free.
  always_comb begin
    s_tready = '0;
    if (state == ST_LOCKED) s_tready[grant] = !m_tvalid || m_tready;
  end

  assign accept  = s_tvalid[grant] && s_tready[grant];
  assign in_last = s_tlast[grant];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (found) state_nxt = ST_LOCKED;
      ST_LOCKED: if (accept && in_last) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // last_grant resets to the top index so stream 0 is searched first.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      grant      <= '0;
      last_grant <= IDW'(NUM_IN-1);
    end else begin
      if (state == ST_IDLE && found) grant      <= sel;
      if (accept && in_last)         last_grant <= grant;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      m_tid    <= '0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tlast  <= in_last;
      m_tdata  <= s_data[grant];
      m_tid    <= grant;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed and randomized checks for rr_stream_arbiter with a queue-driven source model.
module tb_rr_stream_arbiter;

  localparam int NI = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic [NI*DW-1:0]   s_tdata;
  logic [NI-1:0]      s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]      m_tdata;
  logic               m_tvalid, m_tlast, m_tready;
  logic [IW-1:0]      m_tid;

  always #5 ap_clk = ~ap_clk;

  rr_stream_arbiter #(.NUM_IN(NI), .DATA_WIDTH(DW)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tready (m_tready)
  );

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { int tid; logic [DW-1:0] data; logic last; int cyc; } obeat_t;

  beat_t         src_q [NI][$];
  obeat_t        out_q [$];
  obeat_t        acc_q [$];
  logic [NI-1:0] en, took;
  beat_t         took_beat [NI];
  logic          rdy;
  int            cyc, errors, checks;

  function automatic beat_t mk(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    return b;
  endfunction

  task automatic drive();
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = rdy;
    for (int i = 0; i < NI; i++)
      if (en[i] && src_q[i].size() > 0) begin
        s_tvalid[i]         = 1'b1;
        s_tdata[i*DW +: DW] = src_q[i][0].data;
        s_tlast[i]          = src_q[i][0].last;
      end
  endtask

  // One clock: drive, sample handshakes at negedge, retire accepted beats after the edge.
  task automatic cycle();
    logic [NI-1:0] t;
    obeat_t        o;
    drive();
    @(negedge ap_clk);
    t = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      o.tid = int'(m_tid); o.data = m_tdata; o.last = m_tlast; o.cyc = cyc;
      out_q.push_back(o);
    end
    for (int i = 0; i < NI; i++)
      if (t[i]) begin
        o.tid = i; o.data = src_q[i][0].data; o.last = src_q[i][0].last; o.cyc = cyc;
        acc_q.push_back(o);
      end
    @(posedge ap_clk);
    #1;
    cyc++;
    took = t;
    for (int i = 0; i < NI; i++)
      if (t[i]) begin
        took_beat[i] = src_q[i][0];
        void'(src_q[i].pop_front());
      end
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    en = '0;
    rdy = 1'b1;
    for (int i = 0; i < NI; i++) src_q[i].delete();
    out_q.delete();
    acc_q.delete();
    drive();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      src_q[i].push_back(mk(DW'(32'h33 + i), 1'b1));
    end
    en = '1;
    rdy = 1'b1;
    drive();
    #2;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got=%0b want=0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0)  begin errors++; $display("FAIL reset_m_tlast got=%0b want=0", m_tlast); end
    checks++; if (m_tdata !== '0)    begin errors++; $display("FAIL reset_m_tdata got=%h want=0", m_tdata); end
    checks++; if (m_tid !== '0)      begin errors++; $display("FAIL reset_m_tid got=%0d want=0", m_tid); end
    checks++; if (s_tready !== '0)   begin errors++; $display("FAIL reset_s_tready got=%b want=0000", s_tready); end
    repeat (2) @(posedge ap_clk);
    #1;
    checks++; if (s_tready !== '0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_hold s_tready=%b m_tvalid=%0b want 0000/0", s_tready, m_tvalid);
    end
    do_reset();
  endtask

  task automatic test_rr_order();
    int s;
    int exp_tid [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NI; i++) begin
      src_q[i].push_back(mk(DW'(32'h10 + i), 1'b1));
      src_q[i].push_back(mk(DW'(32'h20 + i), 1'b1));
    end
    en = '1;
    s = cyc;
    repeat (14) cycle();
    checks++; if (out_q.size() < 5) begin
      errors++; $display("FAIL rr_count got=%0d want>=5", out_q.size()); return;
    end
    checks++; if (out_q[0].cyc - s != 2) begin
      errors++; $display("FAIL rr_first_latency got=%0d want=2", out_q[0].cyc - s);
    end
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_q[k].tid != exp_tid[k]) begin
        errors++; $display("FAIL rr_tid[%0d] got=%0d want=%0d", k, out_q[k].tid, exp_tid[k]);
      end
      checks++; if (out_q[k].data !== ((k < 4) ? DW'(32'h10 + k) : DW'(32'h20))) begin
        errors++; $display("FAIL rr_data[%0d] got=%h", k, out_q[k].data);
      end
    end
    for (int k = 1; k < 5; k++) begin
      checks++; if (out_q[k].cyc - out_q[k-1].cyc != 2) begin
        errors++; $display("FAIL rr_bubble[%0d] got=%0d want=2", k, out_q[k].cyc - out_q[k-1].cyc);
      end
    end
  endtask

  task automatic test_packet();
    do_reset();
    for (int k = 0; k < 4; k++) src_q[2].push_back(mk(DW'(32'hA0 + k), k == 3));
    en = 4'b0100;
    cycle();
    src_q[1].push_back(mk(32'hB0, 1'b1));
    en = 4'b0110;
    repeat (14) cycle();
    checks++; if (out_q.size() != 5) begin
      errors++; $display("FAIL pkt_count got=%0d want=5", out_q.size()); return;
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_q[k].tid != 2 || out_q[k].data !== DW'(32'hA0 + k) || out_q[k].last !== (k == 3)) begin
        errors++; $display("FAIL pkt_beat[%0d] got tid=%0d data=%h last=%0b want tid=2 data=%h",
                           k, out_q[k].tid, out_q[k].data, out_q[k].last, 32'hA0 + k);
      end
    end
    for (int k = 1; k < 4; k++) begin
      checks++; if (out_q[k].cyc - out_q[k-1].cyc != 1) begin
        errors++; $display("FAIL pkt_contig[%0d] got gap=%0d want=1", k, out_q[k].cyc - out_q[k-1].cyc);
      end
    end
    checks++; if (out_q[4].tid != 1 || out_q[4].data !== 32'hB0 || out_q[4].cyc - out_q[3].cyc != 2) begin
      errors++; $display("FAIL pkt_next got tid=%0d data=%h gap=%0d want tid=1 data=b0 gap=2",
                         out_q[4].tid, out_q[4].data, out_q[4].cyc - out_q[3].cyc);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 6; k++) src_q[0].push_back(mk(DW'(32'hC0 + k), k == 5));
    en = 4'b0001;
    repeat (4) cycle();
    checks++; if (out_q.size() != 2) begin
      errors++; $display("FAIL bp_pre_count got=%0d want=2", out_q.size());
    end
    rdy = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cycle();
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hC2 || s_tready !== '0) begin
        errors++; $display("FAIL bp_hold[%0d] got valid=%0b data=%h ready=%b want 1/c2/0000",
                           n, m_tvalid, m_tdata, s_tready);
      end
    end
    rdy = 1'b1;
    repeat (10) cycle();
    checks++; if (out_q.size() != 6) begin
      errors++; $display("FAIL bp_count got=%0d want=6", out_q.size()); return;
    end
    for (int k = 0; k < 6; k++) begin
      checks++; if (out_q[k].data !== DW'(32'hC0 + k) || out_q[k].last !== (k == 5)) begin
        errors++; $display("FAIL bp_beat[%0d] got data=%h last=%0b want %h", k, out_q[k].data, out_q[k].last, 32'hC0 + k);
      end
    end
  endtask

  task automatic test_valid_gap();
    int exp_tid [5] = '{1, 1, 1, 1, 0};
    do_reset();
    for (int k = 0; k < 4; k++) src_q[1].push_back(mk(DW'(32'hD0 + k), k == 3));
    en = 4'b0010;
    repeat (2) cycle();
    src_q[0].push_back(mk(32'hE0, 1'b1));
    en = 4'b0001;
    for (int n = 0; n < 3; n++) begin
      cycle();
      checks++; if (s_tready[0] !== 1'b0 || took[0] !== 1'b0) begin
        errors++; $display("FAIL gap_lock[%0d] got s_tready=%b took0=%0b want stream0 blocked", n, s_tready, took[0]);
      end
    end
    en = 4'b0011;
    repeat (12) cycle();
    checks++; if (out_q.size() != 5) begin
      errors++; $display("FAIL gap_count got=%0d want=5", out_q.size()); return;
    end
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_q[k].tid != exp_tid[k] || out_q[k].data !== ((k < 4) ? DW'(32'hD0 + k) : DW'(32'hE0))) begin
        errors++; $display("FAIL gap_beat[%0d] got tid=%0d data=%h want tid=%0d", k, out_q[k].tid, out_q[k].data, exp_tid[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    src_q[0].push_back(mk(32'h50, 1'b1));
    en = 4'b0001;
    repeat (4) cycle();
    out_q.delete();
    for (int k = 0; k < 4; k++) src_q[1].push_back(mk(DW'(32'h60 + k), k == 3));
    en = 4'b0010;
    repeat (3) cycle();
    checks++; if (m_tvalid !== 1'b1 || m_tid !== 2'd1) begin
      errors++; $display("FAIL ar_pre got valid=%0b tid=%0d want 1/1", m_tvalid, m_tid);
    end
    #2;
    ap_rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== '0 || m_tdata !== '0) begin
      errors++; $display("FAIL ar_immediate got valid=%0b ready=%b data=%h want 0/0000/0", m_tvalid, s_tready, m_tdata);
    end
    @(posedge ap_clk);
    #1;
    src_q[0].push_back(mk(32'h70, 1'b1));
    en = 4'b0011;
    out_q.delete();
    acc_q.delete();
    repeat (2) cycle();
    checks++; if (out_q.size() != 0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL ar_hold got outs=%0d valid=%0b want 0/0", out_q.size(), m_tvalid);
    end
    ap_rst_n = 1'b1;
    repeat (6) cycle();
    checks++; if (out_q.size() < 1) begin
      errors++; $display("FAIL ar_after got outs=0 want>=1"); return;
    end
    checks++; if (out_q[0].tid != 0 || out_q[0].data !== 32'h70) begin
      errors++; $display("FAIL ar_first got tid=%0d data=%h want tid=0 data=70", out_q[0].tid, out_q[0].data);
    end
  endtask

  task automatic test_random();
    int pk [NI];
    int wait_cnt [NI];
    logic [NI-1:0] mid;
    int max_wait, cur_tid, len, npkt, c;
    bit in_pkt, lock_on, gen, drained;
    int lock_id;
    obeat_t o, a;
    do_reset();
    max_wait = 0; cur_tid = 0; in_pkt = 0; lock_on = 0; lock_id = 0; mid = '0; npkt = 0; drained = 0;
    for (int i = 0; i < NI; i++) begin pk[i] = 0; wait_cnt[i] = 0; end
    for (c = 0; c < 13000 && !drained; c++) begin
      gen = (c < 10000);
      for (int i = 0; i < NI; i++) begin
        if (gen && src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = int'($urandom_range(1, 5));
          for (int b = 0; b < len; b++) src_q[i].push_back(mk({8'(i), 12'(pk[i]), 12'(b)}, b == len - 1));
          pk[i]++;
        end
        en[i] = (gen && mid[i]) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      rdy = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle();
      for (int i = 0; i < NI; i++) begin
        if (!took[i] && !mid[i] && src_q[i].size() > 0)
          for (int j = 0; j < NI; j++)
            if (j != i && took[j] && took_beat[j].last) wait_cnt[i]++;
      end
      for (int i = 0; i < NI; i++)
        if (took[i]) begin
          checks++; if (lock_on && lock_id != i) begin
            errors++; $display("FAIL rnd_lock got stream=%0d want locked stream=%0d", i, lock_id);
          end
          if (!mid[i]) begin
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            wait_cnt[i] = 0;
          end
          lock_on = !took_beat[i].last;
          lock_id = i;
          mid[i]  = !took_beat[i].last;
        end
      while (out_q.size() > 0) begin
        o = out_q.pop_front();
        checks++;
        if (acc_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra got tid=%0d data=%h want no beat", o.tid, o.data);
        end else begin
          a = acc_q.pop_front();
          if (o.tid != a.tid || o.data !== a.data || o.last !== a.last) begin
            errors++; $display("FAIL rnd_beat got tid=%0d data=%h last=%0b want tid=%0d data=%h last=%0b",
                               o.tid, o.data, o.last, a.tid, a.data, a.last);
          end
        end
        checks++; if (in_pkt && o.tid != cur_tid) begin
          errors++; $display("FAIL rnd_interleave got tid=%0d want tid=%0d", o.tid, cur_tid);
        end
        in_pkt = !o.last;
        cur_tid = o.tid;
        if (o.last) npkt++;
      end
      if (!gen) begin
        drained = (acc_q.size() == 0) && !m_tvalid;
        for (int i = 0; i < NI; i++) if (src_q[i].size() != 0) drained = 0;
      end
    end
    checks++; if (!drained) begin
      errors++; $display("FAIL rnd_drain got pending=%0d want 0", acc_q.size());
    end
    checks++; if (max_wait > NI - 1) begin
      errors++; $display("FAIL rnd_starvation got wait=%0d packets want<=%0d", max_wait, NI - 1);
    end
    checks++; if (npkt < 200) begin
      errors++; $display("FAIL rnd_activity got packets=%0d want>=200", npkt);
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    en = '0; rdy = 1'b1;
    drive();
    test_reset();
    test_rr_order();
    test_packet();
    test_backpressure();
    test_valid_gap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_stream_arbiter.md
RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, number of input streams (legal range 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, stream data width in bits (legal range 8..1024).
REQ-003 SHALL have port ap_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port ap_rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port s_tdata, input, NUM_IN*DATA_WIDTH, input data; stream i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have port s_tvalid, input, NUM_IN, per-stream valid.
REQ-007 SHALL have port s_tlast, input, NUM_IN, per-stream end-of-packet.
REQ-008 SHALL have port s_tready, output, NUM_IN, per-stream ready.
REQ-009 SHALL have port m_tdata, output, DATA_WIDTH, output data.
REQ-010 SHALL have port m_tvalid, output, 1, output valid.
REQ-011 SHALL have port m_tlast, output, 1, output end-of-packet.
REQ-012 SHALL have port m_tid, output, IDW = max(1, clog2(NUM_IN)), index of the source stream of the current output beat.
REQ-013 SHALL have port m_tready, input, 1, downstream ready.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no grant) and LOCKED (one stream granted).
REQ-015 In IDLE with any s_tvalid high, SHALL grant the first requesting stream found by searching from (last_grant+1) mod NUM_IN upward with wrap, then enter LOCKED on the next edge.
REQ-016 In IDLE, all s_tready bits SHALL be 0; arbitration costs one cycle.
REQ-017 In LOCKED, s_tready[grant] SHALL equal (!m_tvalid || m_tready), and all other s_tready bits SHALL be 0.
REQ-018 A beat is accepted when s_tvalid[grant] && s_tready[grant]; on acceptance the output register SHALL load tdata, tlast, and grant into m_tdata, m_tlast, and m_tid, and SHALL set m_tvalid.
REQ-019 When m_tvalid && m_tready and no new beat is accepted in the same cycle, m_tvalid SHALL clear.
REQ-020 With m_tready held high, SHALL sustain one beat per cycle within a packet; input-to-output latency SHALL be exactly 1 cycle.
REQ-021 When a beat with tlast=1 is accepted, SHALL update last_grant to the current grant and return to IDLE on that edge; one bubble cycle precedes the next packet.
REQ-022 While m_tvalid=1 and m_tready=0, m_tdata, m_tlast, and m_tid SHALL remain stable.
REQ-023 A granted stream that drops s_tvalid mid-packet SHALL keep the grant; no other stream is served until its tlast is accepted.
REQ-024 m_tid SHALL be computed as an unsigned index; unused upper codes are never produced.

Reset
REQ-025 While ap_rst_n=0, SHALL hold: state=IDLE, last_grant=NUM_IN-1 (so stream 0 wins first), grant=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tid=0, s_tready=0.
REQ-026 Reset asserted mid-packet SHALL discard the in-flight beat and packet lock without producing any partial output after release.
REQ-027 After deassertion, the first arbitration SHALL occur on the first rising edge at which any s_tvalid is high.

Structure
REQ-028 The stream handshake state enum (IDLE, LOCKED) and the IDW width function SHALL reside in a shared package, stream_ctrl_pkg.
REQ-029 The round-robin priority search SHALL be a separate combinational sub-module, rr_prio_select (inputs: request vector, last_grant; outputs: grant index, found).
REQ-030 The output register SHALL be a single pipeline stage with no additional skid buffer.

Verification
REQ-031 After reset, s_tvalid=4'b1111, all tlast=1, m_tready=1 -> m_tid sequence is 0,1,2,3,0 with a bubble cycle between beats.
REQ-032 Stream 2 sends a 4-beat packet 0xA0..0xA3 while stream 1 is valid -> four contiguous m_tid=2 beats, then stream 1 is granted.
REQ-033 Hold m_tready=0 for 5 cycles mid-packet -> m_tdata stays constant, s_tready[grant]=0, and no beat is lost or duplicated.
REQ-034 The granted stream drops tvalid for 3 cycles mid-packet while stream 0 requests -> stream 0 receives no grant until the tlast beat is accepted.
REQ-035 Assert ap_rst_n=0 asynchronously mid-packet -> m_tvalid=0 immediately; after release, stream 0 wins first if it is requesting.
REQ-036 Run random valid/ready/tlast for 10k cycles -> scoreboard shows per-stream packet order preserved, no interleaving within packets, and no starvation (every requester is served within NUM_IN packets).
